// File: rtl/aes_pkg.sv
// Shared AES controller definitions: FSM states, key-length encoding,
// round counts per key length and the key-length to Nr mapping.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KL128 = 2'd0,
    KL192 = 2'd1,
    KL256 = 2'd2
  } key_len_e;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  // Round count for a key-length code; the reserved code falls back to AES-128.
  function automatic int unsigned nr_of(input logic [1:0] key_len);
    case (key_len)
      KL192:   return NR_192;
      KL256:   return NR_256;
      default: return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: round sequencer for the AES datapath (AES-128/192/256,
// encrypt/decrypt). Accepts a block via a valid/ready start handshake, steps
// the round counter once per unstalled cycle, and holds done until done_ack.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   start_valid/ready    block start handshake (ready only in IDLE)
//   key_len, decrypt     configuration, sampled on accept
//   stall                datapath back-pressure; freezes progress, gates enables
//   rnd_no, key_idx      current round and round-key index
//   enb_sb/sr/mc/ar/ks   per-stage enables (RUN and not stalled only)
//   done, done_ack       held completion handshake
//   completed_round      one-hot of the last completed round (bit r-1)
//   abort                only when AES_CTRL_ABORT_EN is defined: drop the
//                        current block and return to IDLE
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = 14,
  parameter int unsigned RND_W      = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [1:0]            key_len,
  input  logic                  decrypt,
  input  logic                  stall,
  output logic [RND_W-1:0]      rnd_no,
  output logic [RND_W-1:0]      key_idx,
  output logic                  enb_sb,
  output logic                  enb_sr,
  output logic                  enb_mc,
  output logic                  enb_ar,
  output logic                  enb_ks,
  output logic                  done,
  input  logic                  done_ack,
`ifdef AES_CTRL_ABORT_EN
  input  logic                  abort,
`endif
  output logic [MAX_ROUNDS-1:0] completed_round
);

  state_e                  state_q, state_d;
  logic [RND_W-1:0]        rnd_q, rnd_d;
  logic [RND_W-1:0]        key_idx_q, key_idx_d;
  logic [RND_W-1:0]        nr_q, nr_d;
  logic                    dec_q, dec_d;
  logic                    done_q, done_d;
  logic                    start_ready_q, start_ready_d;
  logic [MAX_ROUNDS-1:0]   comp_q, comp_d;
  logic                    run_act;

  // Next-state and next-output computation.
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    nr_d      = nr_q;
    dec_d     = dec_q;
    comp_d    = comp_q;

    case (state_q)
      IDLE: begin
        if (start_valid && start_ready_q) begin
          nr_d    = RND_W'(nr_of(key_len));
          dec_d   = decrypt;
          rnd_d   = '0;
          comp_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          // Round 0 is the initial AddRoundKey only and is not recorded.
          if (rnd_q != '0) begin
            comp_d = MAX_ROUNDS'(1) << (rnd_q - RND_W'(1));
          end
          if (rnd_q == nr_q) begin
            rnd_d   = '0;
            state_d = DONE;
          end else begin
            rnd_d = rnd_q + RND_W'(1);
          end
        end
      end
      DONE: begin
        if (done_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        rnd_d   = '0;
        state_d = IDLE;
      end
    endcase

`ifdef AES_CTRL_ABORT_EN
    // Abort outranks stall and done_ack.
    if (abort && (state_q != IDLE)) begin
      rnd_d   = '0;
      comp_d  = '0;
      state_d = IDLE;
    end
`endif

    key_idx_d     = (state_d == RUN) ? (dec_d ? (nr_d - rnd_d) : rnd_d) : '0;
    done_d        = (state_d == DONE);
    start_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      rnd_q         <= '0;
      key_idx_q     <= '0;
      nr_q          <= RND_W'(NR_128);
      dec_q         <= 1'b0;
      comp_q        <= '0;
      done_q        <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      rnd_q         <= rnd_d;
      key_idx_q     <= key_idx_d;
      nr_q          <= nr_d;
      dec_q         <= dec_d;
      comp_q        <= comp_d;
      done_q        <= done_d;
      start_ready_q <= start_ready_d;
    end
  end

  // Enables must drop in the same cycle stall rises, so they are gated
  // combinationally from registered state by the live stall input.
  assign run_act = (state_q == RUN) && !stall;
  assign enb_ar  = run_act;
  assign enb_sb  = run_act && (rnd_q != '0);
  assign enb_sr  = run_act && (rnd_q != '0);
  assign enb_ks  = run_act && (rnd_q != '0);
  assign enb_mc  = run_act && (rnd_q != '0) && (rnd_q != nr_q);

  assign start_ready     = start_ready_q;
  assign rnd_no          = rnd_q;
  assign key_idx         = key_idx_q;
  assign done            = done_q;
  assign completed_round = comp_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: directed and randomized blocks
// compared cycle by cycle against an integer round-progress model.
// AES_CTRL_ABORT_EN enables the abort scenario.
module tb_aes_round_ctrl;

  localparam int unsigned MAX_ROUNDS = 14;
  localparam int unsigned RND_W      = 4;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  start_valid;
  logic                  start_ready;
  logic [1:0]            key_len;
  logic                  decrypt;
  logic                  stall;
  logic [RND_W-1:0]      rnd_no;
  logic [RND_W-1:0]      key_idx;
  logic                  enb_sb, enb_sr, enb_mc, enb_ar, enb_ks;
  logic                  done;
  logic                  done_ack;
  logic [MAX_ROUNDS-1:0] completed_round;
`ifdef AES_CTRL_ABORT_EN
  logic                  abort;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.MAX_ROUNDS(MAX_ROUNDS), .RND_W(RND_W)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .start_valid     (start_valid),
    .start_ready     (start_ready),
    .key_len         (key_len),
    .decrypt         (decrypt),
    .stall           (stall),
    .rnd_no          (rnd_no),
    .key_idx         (key_idx),
    .enb_sb          (enb_sb),
    .enb_sr          (enb_sr),
    .enb_mc          (enb_mc),
    .enb_ar          (enb_ar),
    .enb_ks          (enb_ks),
    .done            (done),
    .done_ack        (done_ack),
`ifdef AES_CTRL_ABORT_EN
    .abort           (abort),
`endif
    .completed_round (completed_round)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nr_model(input logic [1:0] kl);
    if (kl == 2'd1) return 12;
    if (kl == 2'd2) return 14;
    return 10;
  endfunction

  // Last completed round is (rounds advanced - 1); round 0 never counts.
  function automatic logic [31:0] comp_model(input int advanced);
    if (advanced < 2) return 32'd0;
    return 32'd1 << (advanced - 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(start_ready), 32'd1);
    check({tag, "_done"},  32'(done),        32'd0);
    check({tag, "_rnd"},   32'(rnd_no),      32'd0);
    check({tag, "_kidx"},  32'(key_idx),     32'd0);
    check({tag, "_enb"},   32'({enb_sb, enb_sr, enb_mc, enb_ar, enb_ks}), 32'd0);
  endtask

  // Present a start request for one cycle; leaves the DUT in RUN at round 0.
  task automatic accept(input logic [1:0] kl, input logic dec);
    check("acc_ready", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    key_len     = kl;
    decrypt     = dec;
    stall       = 1'($urandom);
    tick();
    start_valid = 1'b0;
    stall       = 1'b0;
    // Changes after accept must be ignored.
    key_len     = 2'($urandom);
    decrypt     = 1'($urandom);
  endtask

  // Runs a complete block, checking every cycle against the model.
  task automatic do_block(input logic [1:0] kl, input logic dec, input int stall_pct,
                          input int stall_at, input int stall_len, input int ack_wait);
    int nr     = nr_model(kl);
    int r      = 0;
    int cyc    = 0;
    int nstall = 0;
    int held   = 0;
    logic s;
    accept(kl, dec);
    forever begin
      check("run_rnd",   32'(rnd_no),  32'(r));
      check("run_kidx",  32'(key_idx), dec ? 32'(nr - r) : 32'(r));
      check("run_done",  32'(done),    32'd0);
      check("run_ready", 32'(start_ready), 32'd0);
      check("run_comp",  32'(completed_round), comp_model(r));
      if (r == stall_at && held < stall_len) begin
        s = 1'b1;
        held++;
      end else begin
        s = ($urandom_range(0, 99) < stall_pct);
      end
      stall = s;
      #1;
      check("enb_ar", 32'(enb_ar), 32'(!s));
      check("enb_sb", 32'({enb_sb, enb_sr, enb_ks}), (!s && r >= 1) ? 32'd7 : 32'd0);
      check("enb_mc", 32'(enb_mc), 32'(!s && r >= 1 && r < nr));
      tick();
      cyc++;
      if (s) begin
        nstall++;
      end else if (r == nr) begin
        break;
      end else begin
        r++;
      end
      if (cyc > 200) begin
        n_checks++;
        n_fail++;
        $error("FAIL run_timeout observed=%0d cycles expected<=200", cyc);
        return;
      end
    end
    stall = 1'($urandom);
    check("lat",        32'(cyc), 32'(nr + 1 + nstall));
    check("done_set",   32'(done), 32'd1);
    check("done_rnd",   32'(rnd_no), 32'd0);
    check("done_enb",   32'({enb_sb, enb_sr, enb_mc, enb_ar, enb_ks}), 32'd0);
    check("done_comp",  32'(completed_round), 32'd1 << (nr - 1));
    check("done_ready", 32'(start_ready), 32'd0);
    for (int i = 0; i < ack_wait; i++) begin
      start_valid = 1'b1;
      key_len     = 2'($urandom);
      tick();
      check("hold_done",  32'(done), 32'd1);
      check("hold_ready", 32'(start_ready), 32'd0);
      check("hold_comp",  32'(completed_round), 32'd1 << (nr - 1));
    end
    start_valid = 1'b0;
    done_ack    = 1'b1;
    tick();
    done_ack = 1'b0;
    stall    = 1'b0;
    check_idle("ack");
    check("ack_comp", 32'(completed_round), 32'd1 << (nr - 1));
  endtask

  initial begin
    rstn        = 1'b0;
    start_valid = 1'b0;
    key_len     = 2'd0;
    decrypt     = 1'b0;
    stall       = 1'b0;
    done_ack    = 1'b0;
`ifdef AES_CTRL_ABORT_EN
    abort       = 1'b0;
`endif
    tick();
    tick();
    check_idle("rst");
    check("rst_comp", 32'(completed_round), 32'd0);
    rstn = 1'b1;
    tick();

    // AES-128 encrypt, no stall.
    do_block(2'd0, 1'b0, 0, -1, 0, 0);
    // AES-256 decrypt.
    do_block(2'd2, 1'b1, 0, -1, 0, 1);
    // AES-192 with a 3-cycle stall at round 5, slow ack.
    do_block(2'd1, 1'b0, 0, 5, 3, 4);
    // Reserved key length behaves as AES-128.
    do_block(2'd3, 1'b1, 0, -1, 0, 0);
    // Randomized blocks.
    for (int b = 0; b < 8; b++) begin
      do_block(2'($urandom), 1'($urandom), 30, -1, 0, $urandom_range(0, 3));
    end

    // Synchronous reset mid-RUN at round 7.
    accept(2'd1, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    check("pre_rst_rnd", 32'(rnd_no), 32'd7);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check_idle("midrst");
    check("midrst_comp", 32'(completed_round), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_nodone", 32'(done), 32'd0);
    end

`ifdef AES_CTRL_ABORT_EN
    // Abort at round 4.
    accept(2'd0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("pre_abort_rnd", 32'(rnd_no), 32'd4);
    abort = 1'b1;
    stall = 1'b1;
    tick();
    abort = 1'b0;
    stall = 1'b0;
    check_idle("abort");
    check("abort_comp", 32'(completed_round), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("abort_nodone", 32'(done), 32'd0);
    end
`endif

    do_block(2'd0, 1'b1, 20, -1, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Parametrised round sequencer for the AES datapath; successor to the fixed AES-128 round counter.
- Supports AES-128/192/256 (Nr = 10/12/14) and encrypt/decrypt.
- Uses a valid/ready start handshake, a datapath stall input and a held done/ack result handshake.
- Sits between the testbench/host and the AES core; drives round number, key-schedule index and per-stage enables.

Parameters:
- MAX_ROUNDS, 14, largest Nr supported; sizes completed_round.
- RND_W, 4, width of rnd_no/key_idx; must satisfy 2^RND_W > MAX_ROUNDS.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- start_valid  in  1  request to begin one block
- start_ready  out  1  controller can accept a request
- key_len  in  2  0=128, 1=192, 2=256, 3=reserved (treated as 128); sampled on accept
- decrypt  in  1  1=inverse cipher; sampled on accept
- stall  in  1  datapath not ready; freezes progress
- rnd_no  out  RND_W  current round, 0..Nr
- key_idx  out  RND_W  round-key index: rnd_no (encrypt) or Nr-rnd_no (decrypt)
- enb_sb, enb_sr, enb_mc, enb_ar, enb_ks  out  1 each  stage enables
- done  out  1  block complete; held until done_ack
- done_ack  in  1  consumer has taken the result
- completed_round  out  MAX_ROUNDS  one-hot of the last completed round, bit r-1 for round r

Behaviour:
- FSM states are IDLE, RUN and DONE.
- Reset: state=IDLE, rnd_no=0, key_idx=0, done=0, all enables=0, completed_round=0, latched cfg=128/encrypt.
- Reset applies at the next edge, including mid-RUN or in DONE; no done pulse is produced.
- IDLE:
  - start_ready=1.
  - Accept = start_valid&start_ready: latch Nr (from key_len) and decrypt, rnd_no<=0, go to RUN.
- RUN:
  - start_ready=0.
  - Each cycle with stall=0 advances one round: rnd_no<=rnd_no+1.
  - If rnd_no==Nr and stall=0: go to DONE, done<=1.
  - stall=1 holds rnd_no and all state, and forces every enable to 0 for that cycle.
- Enables are valid only in RUN with stall=0:
  - enb_ar for rnd_no in 0..Nr.
  - enb_sb, enb_sr, enb_ks for 1..Nr.
  - enb_mc for 1..Nr-1.
  - Enable sets are identical for decrypt; only key_idx differs.
- Latency: accept to done=1 is Nr+1 unstalled cycles, plus one cycle per stalled cycle.
- completed_round:
  - Registered; updated when a round r>=1 finishes unstalled: completed_round<=1<<(r-1).
  - Cleared on accept.
  - Holds its last value through DONE.
- DONE:
  - done=1, rnd_no=0, enables=0.
  - On done_ack: done<=0, go to IDLE.
  - start_ready=0, so a start_valid in DONE is not accepted until IDLE.
- key_len and decrypt changes while not in IDLE are ignored.
- stall in IDLE/DONE has no effect.

Optional Feature:
- Macro: AES_CTRL_ABORT_EN.
- With the macro: adds input abort (1 bit). abort=1 in RUN or DONE forces IDLE at the next edge, with done=0 and completed_round=0. abort has priority over stall and done_ack; it is ignored in IDLE.
- Without the macro: no abort port; a block can only be terminated by rstn.

Decomposition:
- Shared package aes_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - key-length enum {KL128, KL192, KL256};
  - constants NR_128=10, NR_192=12, NR_256=14;
  - function nr_of(key_len).
- No sub-module; a single FSM plus counter.

Test Plan:
- AES-128 encrypt, no stall: accept at cycle 0 -> rnd_no runs 0..10, enb_mc high for rnd_no 1..9 only, done=1 at cycle 11, completed_round=10'h200 (bit 9).
- AES-256 decrypt: key_len=2, decrypt=1 -> 15 RUN cycles; key_idx sequence 14,13,...,0; enb_mc low at rnd_no 0 and 14.
- Stall: AES-192 with stall=1 for 3 cycles at rnd_no=5 -> rnd_no holds 5, enables all 0 while stalled, done at cycle 16 (13+3).
- Handshake: done_ack held 0 for 4 cycles -> done stays 1, start_ready=0 and a start_valid is not accepted; after done_ack, start_ready=1 next cycle.
- Reset mid-RUN: rstn=0 at rnd_no=7 -> next edge IDLE, all outputs at reset values, no done pulse.
- Reserved key_len=3 -> behaves as Nr=10.
- With AES_CTRL_ABORT_EN: abort at rnd_no=4 -> IDLE next edge, done never asserted.
